// File: rtl/uart_tx_if.sv
// Byte handshake between the result formatter and the UART transmitter FIFO.
interface uart_tx_if;
    logic [7:0] Datain;
    logic       Datain_valid;
    logic       Datain_ready;

    modport master (output Datain, output Datain_valid, input Datain_ready);
    modport slave  (input Datain, input Datain_valid, output Datain_ready);
endinterface

// File: rtl/uart_tx.sv
// Buffered 8N1/8N2 UART transmitter: small byte FIFO feeding a start/data/stop
// serializer, with frames sent back-to-back while the FIFO holds data.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 435,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave in_if,
    output logic     TXD,
    output logic     tx_busy
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [BW-1:0] baud;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          push;
    logic          pop;
    logic          strobe;
    logic          stop_done;

    assign in_if.Datain_ready = (count != CW'(FIFO_DEPTH));
    assign push      = in_if.Datain_valid && in_if.Datain_ready;
    assign strobe    = (state != IDLE) && (baud == BW'(CLKS_PER_BIT - 1));
    assign stop_done = strobe && (state == STOP) && (bit_cnt == 3'(STOP_BITS - 1));
    // Pops only happen when the serializer is ready to load: from IDLE, or
    // straight out of the last stop bit so consecutive frames have no gap.
    assign pop       = (count != '0) && ((state == IDLE) || stop_done);
    assign tx_busy   = (state != IDLE) || (count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_if.Datain;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            TXD     <= 1'b1;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            baud    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if ((state == IDLE) || strobe) baud <= '0;
            else                           baud <= baud + 1'b1;

            case (state)
                IDLE: begin
                    TXD     <= 1'b1;
                    bit_cnt <= '0;
                    if (pop) begin
                        shift <= mem[rd_ptr];
                        TXD   <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (strobe) begin
                        TXD     <= shift[0];
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (strobe) begin
                        if (bit_cnt == 3'd7) begin
                            TXD     <= 1'b1;
                            bit_cnt <= '0;
                            state   <= STOP;
                        end else begin
                            shift   <= shift >> 1;
                            TXD     <= shift[1];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (stop_done) begin
                        bit_cnt <= '0;
                        if (pop) begin
                            shift <= mem[rd_ptr];
                            TXD   <= 1'b0;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (strobe) begin
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
